// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the data memory and dmem_arbiter.
// Handshake: a requester holds req with stable we/addr/wdata until gnt; the access occurs in the gnt cycle, and read data returns with rvalid one cycle later.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU priority, debug lock for bursts, read data routed back one cycle later.
// Define DMEM_ARB_STARVE_EN to force a debug grant after MAX_WAIT stalled cycles.
module dmem_arbiter #(
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int MAX_WAIT = 8,
  localparam int WCNT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dmem_arbiter_if.slave     bus,
  output logic              state_o,
  output logic [WCNT_W-1:0] wait_cnt_o
);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [1:0] rd_owner_q, rd_owner_d;
  logic       forced;
  logic       hold_lock;
  logic       cpu_gnt;
  logic       dbg_gnt;

`ifdef DMEM_ARB_STARVE_EN
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign forced = (wait_cnt_q == WCNT_W'(MAX_WAIT)) & bus.dbg_req;

  always_comb begin
    wait_cnt_d = '0;
    if (bus.dbg_req && !dbg_gnt)
      wait_cnt_d = (wait_cnt_q == WCNT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign wait_cnt_o = wait_cnt_q;
`else
  assign forced     = 1'b0;
  assign wait_cnt_o = '0;
`endif

  // A locked cycle that loses dbg_req or dbg_lock falls through to normal arbitration.
  assign hold_lock = (state_q == LOCKED) & bus.dbg_req & bus.dbg_lock;

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst_i) begin
      if (hold_lock || forced) dbg_gnt = 1'b1;
      else if (bus.cpu_req)    cpu_gnt = 1'b1;
      else if (bus.dbg_req)    dbg_gnt = 1'b1;
    end
  end

  always_comb begin
    state_d    = (dbg_gnt && bus.dbg_lock) ? LOCKED : ARB;
    rd_owner_d = {dbg_gnt & ~bus.dbg_we, cpu_gnt & ~bus.cpu_we};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      rd_owner_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dbg_gnt) begin
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  assign bus.mem_en     = cpu_gnt | dbg_gnt;
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;

  // Reset in the return cycle drops the pending rvalid.
  assign bus.cpu_rvalid = rd_owner_q[0] & ~rst_i;
  assign bus.dbg_rvalid = rd_owner_q[1] & ~rst_i;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;

  assign state_o = state_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory between the CPU load/store path and a debug/loader requester (testbench program loader, trigger-driven inspection). It sits between the CPU's ALU-address/store-data path and the data memory. Each cycle it grants at most one requester, drives the memory port from the winner and routes the read data back one cycle later. CPU has priority, with a starvation guard and a debug lock for multi-word transfers.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- MAX_WAIT, 8, debug wait cycles before forced grant (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request (combinational from decode)
- cpu_we  in  1  CPU write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes PC and register write
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req / dbg_we / dbg_lock  in  1  debug request, write, hold-ownership
- dbg_addr  in  ADDR_W; dbg_wdata  in  DATA_W
- dbg_gnt  out  1; dbg_rvalid  out  1; dbg_rdata  out  DATA_W
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en & ~mem_we

## Operation
- State machine: ARB (CPU priority), LOCKED (debug owns port).
- ARB: if forced, grant debug; else cpu_req → CPU; else dbg_req → debug; else none.
- Forced = wait_cnt == MAX_WAIT & dbg_req.
- Grant and mem_* combinational from current requests and registered state; mem_en = cpu_gnt | dbg_gnt; mem_* mux from winner; zero when idle.
- ARB→LOCKED on cycle dbg granted with dbg_lock=1. LOCKED: debug granted whenever dbg_req; CPU never granted. LOCKED→ARB on first cycle with dbg_lock=0 or dbg_req=0 (that cycle evaluates as ARB).
- wait_cnt (clog2(MAX_WAIT+1) bits): +1 each cycle dbg_req & ~dbg_gnt, saturates at MAX_WAIT; cleared on dbg_gnt or dbg_req=0.
- Read return: rd_owner registered on granted read (2'b01 CPU, 2'b10 debug, 0 otherwise); next cycle the owner's rvalid=1, rdata=mem_rdata. Non-owner rdata = 0.
- Writes produce no rvalid. gnt is the completion acknowledgement.
- Requesters hold req/addr/we/wdata stable until gnt. Dropping req before gnt is legal, no access.

## Timing
- Grant latency 0 cycles when uncontested; read data latency 1 cycle after grant.
- Back-to-back grants to either requester every cycle allowed; rvalid pipelines with grants.
- Simultaneous cpu_req & dbg_req, wait_cnt<MAX_WAIT: CPU wins, debug waits.
- Debug worst-case wait MAX_WAIT cycles (starvation guard on) unless CPU is idle.
- Reset: all gnt/rvalid/mem_en/mem_we 0, all rdata/mem_addr/mem_wdata 0, state ARB, wait_cnt 0, rd_owner 0. Reset during pending read drops its rvalid.

## Configuration
- DMEM_ARB_STARVE_EN defined: forced debug grant at wait_cnt==MAX_WAIT as above.
- Undefined: wait_cnt and forcing removed; strict CPU priority in ARB (debug can starve); LOCKED unchanged.

## Test plan
- CPU-only: cpu_req=1, we=0, addr=0x10, mem holds 0xDEADBEEF at 0x10 → cpu_gnt same cycle, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF next cycle, dbg_rvalid=0.
- Contention: both request continuously, MAX_WAIT=8, STARVE_EN → CPU granted cycles 0-7, dbg_gnt cycle 8 with cpu_stall=1, CPU resumes cycle 9; without STARVE_EN dbg_gnt never asserts.
- Lock burst: dbg writes 0x1,0x2,0x3 to 0x100/0x104/0x108 with dbg_lock=1 while cpu_req=1 → three consecutive dbg_gnt, cpu_stall=1 throughout, CPU granted cycle after dbg_lock falls.
- Interleaved reads: CPU read 0x20 cycle 0, debug read 0x24 cycle 1 (CPU idle) → cpu_rvalid cycle 1, dbg_rvalid cycle 2, each with its own word, never both.
- Reset mid-read: grant CPU read, assert rst next cycle → cpu_rvalid=0, all outputs 0, wait_cnt 0, state ARB.
- Abandoned request: dbg_req high 3 cycles behind CPU then drops → no dbg_gnt, wait_cnt returns to 0, mem_we never set for debug.
